// File: rtl/pio_pattern_sequencer.sv
// Autonomous Avalon-MM sequencer: periodically writes an 8-bit pattern to the LED PIO
// and advances it by rotate-left or increment; configured through a 4-word slave.
module pio_pattern_sequencer #(
    parameter int         PERIOD_W = 32,
    parameter logic [1:0] PIO_ADDR = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    output logic [1:0]  dbg_state
);

    // Master handshake: a request (m_chipselect=1, m_write_n=0) is held with stable
    // data until the first cycle m_waitrequest=0; that cycle is the acceptance.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  enable_q, enable_d;
    logic                  mode_q, mode_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [7:0]            pattern_q, pattern_d;
    logic [15:0]           upd_cnt_q, upd_cnt_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic                  m_cs_q, m_cs_d;
    logic                  m_wr_n_q, m_wr_n_d;
    logic [7:0]            m_wdata_q, m_wdata_d;

    logic                  slv_wr;
    logic                  accept;
    logic [PERIOD_W-1:0]   eff_last;

    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        mode_d    = mode_q;
        period_d  = period_q;
        pattern_d = pattern_q;
        upd_cnt_d = upd_cnt_q;
        cnt_d     = cnt_q;
        m_cs_d    = m_cs_q;
        m_wr_n_d  = m_wr_n_q;
        m_wdata_d = m_wdata_q;

        slv_wr   = chipselect & ~write_n;
        accept   = (state_q == ST_WRITE) && !m_waitrequest;
        eff_last = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

        if (accept) begin
            pattern_d = mode_q ? pattern_q + 8'd1 : {pattern_q[6:0], pattern_q[7]};
            upd_cnt_d = upd_cnt_q + 16'd1;
        end

        // Slave writes come after the advance so a CPU pattern load wins.
        if (slv_wr) begin
            case (address)
                2'd0: begin
                    enable_d = writedata[0];
                    mode_d   = writedata[1];
                end
                2'd1:    period_d  = writedata[PERIOD_W-1:0];
                2'd2:    pattern_d = writedata[7:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable_d) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (!enable_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= eff_last) begin
                    state_d   = ST_WRITE;
                    m_cs_d    = 1'b1;
                    m_wr_n_d  = 1'b0;
                    m_wdata_d = pattern_q;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            ST_WRITE: begin
                // The request is never withdrawn, even if enable drops mid-stall.
                if (accept) begin
                    cnt_d    = '0;
                    m_cs_d   = 1'b0;
                    m_wr_n_d = 1'b1;
                    state_d  = enable_q ? ST_COUNT : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            enable_q  <= 1'b0;
            mode_q    <= 1'b0;
            period_q  <= '0;
            pattern_q <= '0;
            upd_cnt_q <= '0;
            cnt_q     <= '0;
            m_cs_q    <= 1'b0;
            m_wr_n_q  <= 1'b1;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            upd_cnt_q <= upd_cnt_d;
            cnt_q     <= cnt_d;
            m_cs_q    <= m_cs_d;
            m_wr_n_q  <= m_wr_n_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    always_comb begin
        case (address)
            2'd0:    readdata = {30'd0, mode_q, enable_q};
            2'd1:    readdata = 32'(period_q);
            2'd2:    readdata = {24'd0, pattern_q};
            default: readdata = {upd_cnt_q, pattern_q, 7'd0, m_cs_q};
        endcase
    end

    assign m_address    = PIO_ADDR;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = m_wr_n_q;
    assign m_writedata  = {24'd0, m_wdata_q};
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Bench for pio_pattern_sequencer: register table, PIO write scoreboard and
// hand-written sequences for stalls, pattern override, period shrink and reset.
module tb_pio_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
    logic [1:0]  dbg_state;

    pio_pattern_sequencer #(.PERIOD_W(32), .PIO_ADDR(2'd0)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_waitrequest(m_waitrequest),
        .dbg_state    (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // accepted PIO writes, logged mid-cycle
    logic [31:0] acc_data[$];
    int          acc_cyc[$];
    always @(negedge clk) begin
        if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
            acc_data.push_back(m_writedata);
            acc_cyc.push_back(cyc);
        end
    end

    logic [31:0] exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int rd_idx = 0;
    int last_wr_cyc = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        last_wr_cyc = cyc;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_data.size() < target && n < budget) begin
            step();
            n++;
        end
        chk("wait_acc_count", 32'(acc_data.size() >= target), 32'd1);
    endtask

    task automatic wait_cs(input int budget);
        int n = 0;
        while (!m_chipselect && n < budget) begin
            step();
            n++;
        end
        chk("wait_cs", {31'd0, m_chipselect}, 32'd1);
    endtask

    task automatic sb_drain();
        while (rd_idx < acc_data.size()) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pio_write", acc_data[rd_idx], 32'hxxxx_xxxx);
            end else begin
                chk("pio_wdata", acc_data[rd_idx], exp_q.pop_front());
            end
            rd_idx++;
        end
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_gaps(input int base, input int n, input int gap);
        for (int i = 1; i < n; i++) begin
            if (base + i < acc_cyc.size())
                chk("write_gap", 32'(acc_cyc[base+i] - acc_cyc[base+i-1]), 32'(gap));
        end
    endtask

    initial begin
        int base;
        int t_en;

        // reset state
        repeat (3) step();
        reset = 1'b0;
        step();
        rd_chk("rst_control", 2'd0, 32'd0);
        rd_chk("rst_period",  2'd1, 32'd0);
        rd_chk("rst_pattern", 2'd2, 32'd0);
        rd_chk("rst_status",  2'd3, 32'd0);
        chk("rst_m_cs", {31'd0, m_chipselect}, 32'd0);
        chk("rst_m_wn", {31'd0, m_write_n}, 32'd1);
        chk("rst_m_wdata", m_writedata, 32'd0);
        chk("rst_m_addr", {30'd0, m_address}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);

        // register table (enable kept 0 throughout)
        vecs[0] = '{2'd1, 32'd4,          32'd4};
        vecs[1] = '{2'd2, 32'h0000_01A5,  32'h0000_00A5};
        vecs[2] = '{2'd0, 32'hFFFF_FFFE,  32'h0000_0002};
        vecs[3] = '{2'd3, 32'hFFFF_FFFF,  32'h0000_A500};
        vecs[4] = '{2'd1, 32'hDEAD_BEEF,  32'hDEAD_BEEF};
        vecs[5] = '{2'd2, 32'd0,          32'd0};
        vecs[6] = '{2'd0, 32'd0,          32'd0};
        for (int i = 0; i < 7; i++) begin
            reg_write(vecs[i].addr, vecs[i].wdata);
            rd_chk($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp_rd);
        end
        step();
        sb_drain();

        // rotate mode, period 4
        base = acc_data.size();
        exp_q.push_back(32'h81); exp_q.push_back(32'h03);
        exp_q.push_back(32'h06); exp_q.push_back(32'h0C);
        reg_write(2'd2, 32'h81);
        reg_write(2'd1, 32'd4);
        reg_write(2'd0, 32'd1);
        t_en = last_wr_cyc;
        wait_acc(base + 4, 60);
        reg_write(2'd0, 32'd0);
        repeat (10) step();
        sb_drain();
        if (acc_cyc.size() > base) chk("first_latency", 32'(acc_cyc[base]), 32'(t_en + 5));
        chk_gaps(base, 4, 5);
        rd_chk("rot_status", 2'd3, 32'h0004_1800);
        chk("rot_idle", {30'd0, dbg_state}, 32'd0);

        // increment mode, period 0 behaves as 1
        base = acc_data.size();
        exp_q.push_back(32'hFE); exp_q.push_back(32'hFF);
        exp_q.push_back(32'h00); exp_q.push_back(32'h01);
        reg_write(2'd2, 32'hFE);
        reg_write(2'd1, 32'd0);
        reg_write(2'd0, 32'd3);
        t_en = last_wr_cyc;
        wait_acc(base + 3, 40);
        reg_write(2'd0, 32'd2);
        repeat (10) step();
        sb_drain();
        if (acc_cyc.size() > base) chk("inc_latency", 32'(acc_cyc[base]), 32'(t_en + 2));
        chk_gaps(base, 4, 2);
        rd_chk("inc_status", 2'd3, 32'h0008_0200);
        rd_chk("inc_control", 2'd0, 32'd2);

        // wait-state stall with enable cleared mid-stall
        exp_q.push_back(32'h3C);
        reg_write(2'd2, 32'h3C);
        reg_write(2'd1, 32'd3);
        reg_write(2'd0, 32'd1);
        m_waitrequest = 1'b1;
        wait_cs(20);
        rd_chk("stall_busy", 2'd3, 32'h0008_3C01);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_cs%0d", i), {31'd0, m_chipselect}, 32'd1);
            chk($sformatf("stall_wn%0d", i), {31'd0, m_write_n}, 32'd0);
            chk($sformatf("stall_wd%0d", i), m_writedata, 32'h3C);
            if (i == 0) begin
                address = 2'd0; writedata = 32'd0; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                chipselect = 1'b0; write_n = 1'b1;
            end
            step();
        end
        m_waitrequest = 1'b0;
        repeat (12) step();
        sb_drain();
        chk("stall_idle", {30'd0, dbg_state}, 32'd0);
        rd_chk("stall_status", 2'd3, 32'h0009_7800);

        // CPU pattern loads: cycle after acceptance, then same cycle as acceptance
        base = acc_data.size();
        exp_q.push_back(32'h11); exp_q.push_back(32'h55); exp_q.push_back(32'hAA);
        reg_write(2'd2, 32'h11);
        reg_write(2'd1, 32'd4);
        reg_write(2'd0, 32'd1);
        wait_acc(base + 1, 30);
        reg_write(2'd2, 32'h55);
        wait_acc(base + 2, 30);
        m_waitrequest = 1'b1;
        wait_cs(20);
        m_waitrequest = 1'b0;
        address = 2'd2; writedata = 32'h99; chipselect = 1'b1; write_n = 1'b0;
        step();
        address = 2'd0; writedata = 32'd0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
        repeat (10) step();
        sb_drain();
        rd_chk("override_status", 2'd3, 32'h000C_9900);

        // period shrink from 100 to 2 at count 50, then reset mid-WRITE
        base = acc_data.size();
        exp_q.push_back(32'h01); exp_q.push_back(32'h02); exp_q.push_back(32'h04);
        reg_write(2'd2, 32'h01);
        reg_write(2'd1, 32'd100);
        reg_write(2'd0, 32'd1);
        t_en = last_wr_cyc;
        while (cyc < t_en + 51) step();
        reg_write(2'd1, 32'd2);
        wait_acc(base + 3, 30);
        if (acc_cyc.size() > base) chk("shrink_latency", 32'(acc_cyc[base]), 32'(t_en + 53));
        chk_gaps(base, 3, 3);
        m_waitrequest = 1'b1;
        wait_cs(20);
        reset = 1'b1;
        #1;
        chk("arst_m_cs", {31'd0, m_chipselect}, 32'd0);
        chk("arst_m_wn", {31'd0, m_write_n}, 32'd1);
        chk("arst_m_wdata", m_writedata, 32'd0);
        chk("arst_state", {30'd0, dbg_state}, 32'd0);
        rd_chk("arst_status", 2'd3, 32'd0);
        rd_chk("arst_control", 2'd0, 32'd0);
        step();
        step();
        reset = 1'b0;
        m_waitrequest = 1'b0;
        repeat (12) step();
        sb_drain();
        chk("post_rst_m_cs", {31'd0, m_chipselect}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
